dnpcie_aurora_rx_nfc_buffer: RTL and testbench

//  Consumer of the Aurora 8b10b RX user interface, which has no backpressure: all valid words are buffered in a sync FIFO.
//  Re-presents the data as an AXI4-Stream master with tready.

---
 rtl/dnpcie_aurora_pkg.sv | 27 ++
 rtl/dnpcie_aurora_rx_nfc_buffer_if.sv | 11 +
 rtl/aurora_rx_sync_fifo.sv | 87 ++++++++
 rtl/dnpcie_aurora_rx_nfc_buffer.sv | 192 +++++++++++++++++++
 tb/tb_dnpcie_aurora_rx_nfc_buffer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dnpcie_aurora_pkg.sv
// Shared types and constants for the Aurora RX buffer with NFC flow control.
package dnpcie_aurora_pkg;

    // Native flow control codes driven on the core's NFC TX port
    localparam logic [3:0] NFC_XOFF = 4'hF;
    localparam logic [3:0] NFC_XON  = 4'h0;

    typedef enum logic [1:0] {
        XON_IDLE  = 2'd0,
        SEND_XOFF = 2'd1,
        XOFF      = 2'd2,
        SEND_XON  = 2'd3
    } nfc_state_t;

    // One buffered RX beat: data in Aurora [0:31] order, byte keep, end of frame
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } rx_word_t;

    // True while the link partner has been (or is being) told to stop
    function automatic logic nfc_state_is_off(input nfc_state_t s);
        return (s == SEND_XOFF) || (s == XOFF);
    endfunction

endpackage

// File: rtl/dnpcie_aurora_rx_nfc_buffer_if.sv
// AXI4-Stream bundle carrying buffered RX words to the packet consumer.
interface dnpcie_aurora_rx_nfc_buffer_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/aurora_rx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The RAM read register doubles as
// the output register, so a word written into an empty FIFO is presented two
// cycles later. level counts words in RAM plus the output register.
module aurora_rx_sync_fifo #(
    parameter int WIDTH      = 37,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full
);
    localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE        = (DEPTH_LOG2 + 1)'(1);

    logic [WIDTH-1:0]    mem_r [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_r;
    logic [DEPTH_LOG2:0] rd_ptr_r;
    logic [DEPTH_LOG2:0] level_r;
    logic [WIDTH-1:0]    out_data_r;
    logic                out_valid_r;
    logic                ram_empty_s;
    logic                push_s;
    logic                pop_s;
    logic                load_s;

    // Handshake decode: load the output register whenever it is free or being consumed
    always_comb begin
        ram_empty_s = (wr_ptr_r == rd_ptr_r);
        push_s      = wr_en & (level_r != FULL_LEVEL);
        pop_s       = out_valid_r & rd_en;
        load_s      = ~ram_empty_s & (~out_valid_r | rd_en);
    end

    // RAM write port (no reset so it maps onto block RAM)
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    // RAM read register, which is also the FWFT output register
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_r <= '0;
        end else if (load_s) begin
            out_data_r <= mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
        end
    end

    // Pointers, output valid and fill level
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE;
            end
            if (load_s) begin
                rd_ptr_r    <= rd_ptr_r + ONE;
                out_valid_r <= 1'b1;
            end else if (pop_s) begin
                out_valid_r <= 1'b0;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + ONE;
                2'b01:   level_r <= level_r - ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    assign rd_data  = out_data_r;
    assign rd_valid = out_valid_r;
    assign level    = level_r;
    assign full     = (level_r == FULL_LEVEL);

endmodule

// File: rtl/dnpcie_aurora_rx_nfc_buffer.sv
// Aurora RX buffer: absorbs the backpressure-free RX user interface into a
// FIFO, re-presents it as an AXI4-Stream master and throttles the link partner
// with native flow control (XOFF at the high watermark, XON at the low one).
// Optional: define AURORA_RX_STATS_EN to add frame_count / drop_count outputs.
module dnpcie_aurora_rx_nfc_buffer
    import dnpcie_aurora_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int HI_WM      = 448,
    parameter int LO_WM      = 128,
    parameter int SKID       = 48
) (
    input  logic                        user_clk,
    input  logic                        reset,
    input  logic                        channel_up,
    input  logic [31:0]                 aur_rx_tdata,
    input  logic [3:0]                  aur_rx_tkeep,
    input  logic                        aur_rx_tvalid,
    input  logic                        aur_rx_tlast,
    output logic                        nfc_tx_tvalid,
    output logic [3:0]                  nfc_tx_tdata,
    input  logic                        nfc_tx_tready,
    dnpcie_aurora_rx_nfc_buffer_if.master m_axis,
    output logic [DEPTH_LOG2:0]         fifo_level,
    output logic                        xoff_active,
    output logic                        overflow,
    input  logic                        overflow_clr
`ifdef AURORA_RX_STATS_EN
    ,
    output logic [31:0]                 frame_count,
    output logic [15:0]                 drop_count
`endif
);
    localparam logic [DEPTH_LOG2:0] HI_LVL = (DEPTH_LOG2 + 1)'(HI_WM);
    localparam logic [DEPTH_LOG2:0] LO_LVL = (DEPTH_LOG2 + 1)'(LO_WM);

    // Words in flight after XOFF must still fit above the high watermark
    if ((2 ** DEPTH_LOG2) - HI_WM < SKID) begin : g_bad_skid
        $error("dnpcie_aurora_rx_nfc_buffer: 2**DEPTH_LOG2 - HI_WM must be >= SKID");
    end
    if (LO_WM >= HI_WM) begin : g_bad_wm
        $error("dnpcie_aurora_rx_nfc_buffer: LO_WM must be below HI_WM");
    end

    rx_word_t            rx_word_s;
    rx_word_t            out_word_s;
    logic                out_valid_s;
    logic                full_s;
    logic [DEPTH_LOG2:0] level_s;
    logic                wr_s;
    logic                drop_s;
    logic                overflow_r;
    nfc_state_t          state_r;
    nfc_state_t          state_next_s;
    logic                req_valid_s;
    logic [3:0]          req_code_s;
    logic                nfc_tvalid_r;
    logic [3:0]          nfc_tdata_r;
    logic                xoff_active_r;

    // Write qualification: words seen while the channel is down are ignored
    always_comb begin
        rx_word_s.data = aur_rx_tdata;
        rx_word_s.keep = aur_rx_tkeep;
        rx_word_s.last = aur_rx_tlast;
        wr_s           = aur_rx_tvalid & channel_up & ~full_s;
        drop_s         = aur_rx_tvalid & channel_up & full_s;
    end

    aurora_rx_sync_fifo #(
        .WIDTH      ($bits(rx_word_t)),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk      (user_clk),
        .reset    (reset),
        .wr_en    (wr_s),
        .wr_data  (rx_word_s),
        .rd_en    (m_axis.tready),
        .rd_data  (out_word_s),
        .rd_valid (out_valid_s),
        .level    (level_s),
        .full     (full_s)
    );

    assign m_axis.tdata  = out_word_s.data;
    assign m_axis.tkeep  = out_word_s.keep;
    assign m_axis.tlast  = out_word_s.last;
    assign m_axis.tvalid = out_valid_s;
    assign fifo_level    = level_s;

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge user_clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (overflow_clr) begin
            overflow_r <= 1'b0;
        end
    end

    assign overflow = overflow_r;

    // NFC next state with hysteresis, then the request implied by that state
    always_comb begin
        state_next_s = state_r;
        req_valid_s  = 1'b0;
        req_code_s   = NFC_XON;
        case (state_r)
            XON_IDLE: begin
                if (level_s >= HI_LVL) state_next_s = SEND_XOFF;
                else                   state_next_s = XON_IDLE;
            end
            SEND_XOFF: begin
                if (nfc_tx_tready) state_next_s = XOFF;
                else               state_next_s = SEND_XOFF;
            end
            XOFF: begin
                if (level_s <= LO_LVL) state_next_s = SEND_XON;
                else                   state_next_s = XOFF;
            end
            SEND_XON: begin
                if (nfc_tx_tready) state_next_s = XON_IDLE;
                else               state_next_s = SEND_XON;
            end
            default: state_next_s = XON_IDLE;
        endcase
        // Link down: the core discards NFC, so abandon any request
        if (!channel_up) begin
            state_next_s = XON_IDLE;
        end else begin
            state_next_s = state_next_s;
        end
        case (state_next_s)
            SEND_XOFF: begin
                req_valid_s = 1'b1;
                req_code_s  = NFC_XOFF;
            end
            SEND_XON: begin
                req_valid_s = 1'b1;
                req_code_s  = NFC_XON;
            end
            default: begin
                req_valid_s = 1'b0;
                req_code_s  = NFC_XON;
            end
        endcase
    end

    // NFC state register and registered request outputs
    always_ff @(posedge user_clk) begin
        if (reset) begin
            state_r       <= XON_IDLE;
            nfc_tvalid_r  <= 1'b0;
            nfc_tdata_r   <= 4'h0;
            xoff_active_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            nfc_tvalid_r  <= req_valid_s;
            nfc_tdata_r   <= req_code_s;
            xoff_active_r <= nfc_state_is_off(state_next_s);
        end
    end

    assign nfc_tx_tvalid = nfc_tvalid_r;
    assign nfc_tx_tdata  = nfc_tdata_r;
    assign xoff_active   = xoff_active_r;

`ifdef AURORA_RX_STATS_EN
    logic [31:0] frame_count_r;
    logic [15:0] drop_count_r;

    // Accepted-frame counter (wraps) and dropped-word counter (saturates)
    always_ff @(posedge user_clk) begin
        if (reset) begin
            frame_count_r <= 32'd0;
            drop_count_r  <= 16'd0;
        end else begin
            if (wr_s && aur_rx_tlast) begin
                frame_count_r <= frame_count_r + 32'd1;
            end
            if (drop_s && (drop_count_r != 16'hFFFF)) begin
                drop_count_r <= drop_count_r + 16'd1;
            end
        end
    end

    assign frame_count = frame_count_r;
    assign drop_count  = drop_count_r;
`endif

endmodule

// File: tb/tb_dnpcie_aurora_rx_nfc_buffer.sv
// Self-checking bench for dnpcie_aurora_rx_nfc_buffer: a hand-built vector
// table, directed watermark / overflow / link-down / reset sequences and a
// randomized phase, all compared against a queue-based reference model.
module tb_dnpcie_aurora_rx_nfc_buffer;

    localparam int DEPTH = 512;
    localparam int HI_WM = 448;
    localparam int LO_WM = 128;

    logic        user_clk = 1'b0;
    logic        reset;
    logic        channel_up;
    logic [31:0] aur_rx_tdata;
    logic [3:0]  aur_rx_tkeep;
    logic        aur_rx_tvalid;
    logic        aur_rx_tlast;
    logic        nfc_tx_tvalid;
    logic [3:0]  nfc_tx_tdata;
    logic        nfc_tx_tready;
    logic [9:0]  fifo_level;
    logic        xoff_active;
    logic        overflow;
    logic        overflow_clr;
`ifdef AURORA_RX_STATS_EN
    logic [31:0] frame_count;
    logic [15:0] drop_count;
`endif

    dnpcie_aurora_rx_nfc_buffer_if m_axis_if();

    dnpcie_aurora_rx_nfc_buffer dut (
        .user_clk      (user_clk),
        .reset         (reset),
        .channel_up    (channel_up),
        .aur_rx_tdata  (aur_rx_tdata),
        .aur_rx_tkeep  (aur_rx_tkeep),
        .aur_rx_tvalid (aur_rx_tvalid),
        .aur_rx_tlast  (aur_rx_tlast),
        .nfc_tx_tvalid (nfc_tx_tvalid),
        .nfc_tx_tdata  (nfc_tx_tdata),
        .nfc_tx_tready (nfc_tx_tready),
        .m_axis        (m_axis_if),
        .fifo_level    (fifo_level),
        .xoff_active   (xoff_active),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr)
`ifdef AURORA_RX_STATS_EN
        ,
        .frame_count   (frame_count),
        .drop_count    (drop_count)
`endif
    );

    always #5 user_clk = ~user_clk;

    // Reference model: every held word with the cycle it was written
    typedef struct {
        logic [36:0] w;
        int          t;
    } mword_t;

    mword_t     mq[$];
    int         cyc;
    logic       m_ovf;
    int         m_frames;
    int         m_drops;
    bit         hi_seen;
    int         checks;
    int         errors;
    int         nfc_hs;
    logic [3:0] nfc_last;

    // The head word is presented once it has been held for two cycles
    function automatic bit m_valid();
        return (mq.size() > 0) && (mq[0].t + 2 <= cyc);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs, advance the clock, update the model, compare
    task automatic step(input logic v, input logic [36:0] w, input logic rdy,
                        input logic cu, input logic clr, input logic nrdy);
        bit pop;
        bit full;
        bit wr;
        bit drop;
        aur_rx_tvalid    = v;
        aur_rx_tdata     = w[36:5];
        aur_rx_tkeep     = w[4:1];
        aur_rx_tlast     = w[0];
        m_axis_if.tready = rdy;
        channel_up       = cu;
        overflow_clr     = clr;
        nfc_tx_tready    = nrdy;
        if (nfc_tx_tvalid && nrdy) begin
            nfc_hs++;
            nfc_last = nfc_tx_tdata;
        end
        pop  = m_valid() && rdy;
        full = (mq.size() == DEPTH);
        wr   = v && cu && !full;
        drop = v && cu && full;
        @(posedge user_clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (wr) begin
            mq.push_back('{w, cyc});
            if (w[0]) m_frames++;
        end
        if (drop) begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
        end else if (clr) begin
            m_ovf = 1'b0;
        end
        cyc++;
        if (mq.size() >= HI_WM) hi_seen = 1'b1;
        chk("m_axis_tvalid", m_axis_if.tvalid, m_valid());
        if (m_valid()) chk("m_axis_word", {m_axis_if.tdata, m_axis_if.tkeep, m_axis_if.tlast}, mq[0].w);
        chk("fifo_level", fifo_level, mq.size());
        chk("overflow", overflow, m_ovf);
        if (!hi_seen) chk("nfc_quiet", nfc_tx_tvalid, 64'd0);
`ifdef AURORA_RX_STATS_EN
        chk("frame_count", frame_count, m_frames);
        chk("drop_count", drop_count, m_drops);
`endif
    endtask

    task automatic idle(input logic rdy, input logic nrdy);
        step(1'b0, 37'd0, rdy, 1'b1, 1'b0, nrdy);
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        aur_rx_tvalid    = 1'b0;
        aur_rx_tdata     = 32'd0;
        aur_rx_tkeep     = 4'd0;
        aur_rx_tlast     = 1'b0;
        m_axis_if.tready = 1'b0;
        channel_up       = 1'b1;
        overflow_clr     = 1'b0;
        nfc_tx_tready    = 1'b0;
        @(posedge user_clk);
        #1;
        reset = 1'b0;
        mq.delete();
        m_ovf    = 1'b0;
        m_frames = 0;
        m_drops  = 0;
        hi_seen  = 1'b0;
        cyc++;
        chk("rst_level", fifo_level, 64'd0);
        chk("rst_tvalid", m_axis_if.tvalid, 64'd0);
        chk("rst_xoff_active", xoff_active, 64'd0);
        chk("rst_nfc_tvalid", nfc_tx_tvalid, 64'd0);
        chk("rst_overflow", overflow, 64'd0);
    endtask

    function automatic logic [36:0] seq_word(input int i, input bit last);
        logic [31:0] d;
        d = 32'hC0DE_0000 + 32'(i);
        return {d, 4'hF, last};
    endfunction

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        last;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_d;
        logic        exp_last;
        int          exp_level;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int hs_base;
        // Each entry: inputs for this cycle, outputs expected at its start
        vecs[0] = '{1'b1, 32'hA1A1_0001, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 0};
        vecs[1] = '{1'b1, 32'hA1A1_0002, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1};
        vecs[2] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hA1A1_0001, 1'b0, 2};
        vecs[3] = '{1'b1, 32'hA1A1_0003, 1'b1, 1'b1, 1'b1, 32'hA1A1_0001, 1'b0, 2};
        vecs[4] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hA1A1_0002, 1'b0, 2};
        vecs[5] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hA1A1_0003, 1'b1, 1};
        vecs[6] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 0};

        checks   = 0;
        errors   = 0;
        cyc      = 0;
        nfc_hs   = 0;
        nfc_last = 4'h5;
        do_reset();

        // Table: FWFT latency, hold under !tready, back-to-back reads
        for (int k = 0; k < 7; k++) begin
            chk("tbl_tvalid", m_axis_if.tvalid, vecs[k].exp_valid);
            chk("tbl_level", fifo_level, vecs[k].exp_level);
            if (vecs[k].exp_valid)
                chk("tbl_data", {m_axis_if.tdata, m_axis_if.tlast}, {vecs[k].exp_d, vecs[k].exp_last});
            step(vecs[k].v, {vecs[k].d, 4'hF, vecs[k].last}, vecs[k].rdy, 1'b1, 1'b0, 1'b1);
        end

        // 10-word frame with tready held high
        for (int i = 0; i < 10; i++) step(1'b1, seq_word(i, i == 9), 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b1);
        chk("frame_overflow", overflow, 64'd0);

        // Randomized traffic, drain-biased so the high watermark stays out of reach
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 40,
                 {$urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))},
                 $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 95,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 1) == 1);
        end

        // Fill to HI_WM with the consumer stalled: XOFF follows one cycle later and holds
        do_reset();
        for (int i = 0; i < HI_WM; i++) step(1'b1, seq_word(i, 1'b0), 1'b0, 1'b1, 1'b0, 1'b0);
        chk("xoff_not_yet", nfc_tx_tvalid, 64'd0);
        idle(1'b0, 1'b0);
        chk("xoff_tvalid", nfc_tx_tvalid, 64'd1);
        chk("xoff_tdata", nfc_tx_tdata, 64'hF);
        chk("xoff_active", xoff_active, 64'd1);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0, 1'b0);
            chk("xoff_hold_tvalid", nfc_tx_tvalid, 64'd1);
            chk("xoff_hold_tdata", nfc_tx_tdata, 64'hF);
        end
        idle(1'b0, 1'b1);
        chk("xoff_done_tvalid", nfc_tx_tvalid, 64'd0);
        chk("xoff_state_active", xoff_active, 64'd1);

        // Drain to LO_WM: exactly one XON, then no traffic on a partial refill
        hs_base = nfc_hs;
        for (int i = 0; i < 1000 && mq.size() > LO_WM; i++) idle(1'b1, 1'b1);
        chk("xon_level", fifo_level, LO_WM);
        chk("xon_not_yet", nfc_tx_tvalid, 64'd0);
        idle(1'b1, 1'b1);
        chk("xon_tvalid", nfc_tx_tvalid, 64'd1);
        chk("xon_tdata", nfc_tx_tdata, 64'h0);
        chk("xon_inactive", xoff_active, 64'd0);
        for (int i = 0; i < 200 && mq.size() > 0; i++) idle(1'b1, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, seq_word(i, 1'b1), 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 400 && mq.size() > 100; i++) idle(1'b1, 1'b1);
        chk("single_xon", nfc_hs - hs_base, 64'd1);
        chk("xon_code", nfc_last, 64'h0);

        // Overflow: word 513 dropped; set beats clear in the same cycle
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, seq_word(i, 1'b0), 1'b0, 1'b1, 1'b0, 1'b1);
        chk("ovf_set", overflow, 64'd1);
        chk("ovf_full_level", fifo_level, DEPTH);
`ifdef AURORA_RX_STATS_EN
        chk("ovf_drop_count", drop_count, 64'd1);
`endif
        step(1'b1, seq_word(999, 1'b0), 1'b0, 1'b1, 1'b1, 1'b1);
        chk("ovf_set_wins", overflow, 64'd1);
        step(1'b0, 37'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("ovf_cleared", overflow, 64'd0);

        // Channel down during SEND_XOFF: request dropped, RX words ignored
        do_reset();
        for (int i = 0; i < HI_WM; i++) step(1'b1, seq_word(i, 1'b0), 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("cd_xoff_tvalid", nfc_tx_tvalid, 64'd1);
        step(1'b1, seq_word(7, 1'b1), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("cd_tvalid_drop", nfc_tx_tvalid, 64'd0);
        chk("cd_xoff_inactive", xoff_active, 64'd0);
        step(1'b1, seq_word(8, 1'b1), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("cd_level_kept", fifo_level, HI_WM);
        chk("cd_still_idle", nfc_tx_tvalid, 64'd0);

        // Synchronous reset while in XOFF at level 200
        do_reset();
        for (int i = 0; i < HI_WM; i++) step(1'b1, seq_word(i, 1'b0), 1'b0, 1'b1, 1'b0, 1'b1);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        for (int i = 0; i < 400 && mq.size() > 200; i++) idle(1'b1, 1'b1);
        chk("pre_rst_level", fifo_level, 64'd200);
        chk("pre_rst_xoff", xoff_active, 64'd1);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
